issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//  Register scoreboard and issue gate between instruction decode and execute.
//  Takes the decoded operand fields (src1, src2, dest) plus the 2-bit instruction type.
//  Tracks pending writes to registers r1..r31 and holds issue on RAW/WAW hazards or when too many writes are in flight.
//  Writebacks from execute release registers.
// PARAMETERS
//  MAX_INFLIGHT  4   max outstanding register writes (1..31)
//  CNT_W         3   width of inflight; must hold MAX_INFLIGHT
//  STALL_W       16  width of saturating stall counter
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      synchronous reset, active-high
//  flush        in   1      drop all outstanding writes (pipeline flush)
//  issue_valid  in   1      decode presents an instruction
//  issue_ready  out  1      scoreboard accepts it (combinational)
//  issue_type   in   2      00 none, 01 S-type, 10 I-type, 11 B-type
//  src1         in   5      source register 1
//  src2         in   5      source register 2
//  dest         in   5      destination register
//  wb_valid     in   1      execute writes back a register this cycle
//  wb_dest      in   5      register being written back
//  busy_vec     out  32     bit n = write to rn pending; bit 0 always 0
//  inflight     out  CNT_W  number of set busy bits
//  stall_cnt    out  STALL_W  cycles with issue_valid & !issue_ready, saturating
//  wb_err       out  1      sticky: writeback to a non-busy register seen
// BEHAVIOUR
//  Clocking and reset
//  - Single clock. Reset is synchronous, active-high.
//  - rst: busy_vec=0, inflight=0, stall_cnt=0, wb_err=0. rst wins over every other input.
//  Operand usage per type
//  - 01: reads src1, src2; writes dest.
//  - 10: reads src1; writes dest.
//  - 11: reads src2; writes nothing.
//  - 00: reads and writes nothing.
//  - r0 is the zero register: never read-hazarded, never marked busy.
//  Issue gate
//  - busy_eff = busy_vec & ~(wb_valid ? onehot(wb_dest) : 0).
//  - Same-cycle writeback bypasses into the hazard check.
//  - issue_ready = 1 when all of the following hold:
//    - no used source has busy_eff set (RAW);
//    - if writing, dest has no busy_eff bit set (WAW);
//    - if writing a nonzero dest, (inflight - wb_release) < MAX_INFLIGHT.
//  - issue_ready = 0 during flush. It is independent of issue_valid.
//  - fire = issue_valid & issue_ready. No internal latency: busy set takes effect on the next edge.
//  Writeback
//  - wb_release = wb_valid & busy_vec[wb_dest] & (wb_dest!=0). It clears that bit next edge.
//  - wb_valid to a non-busy reg, or to r0: no state change, wb_err <= 1 (sticky until rst).
//  Simultaneous events
//  - Writeback and issue to the same dest in one cycle: wb clears, then fire sets; the bit ends 1.
//  - inflight next = inflight + fire_write - wb_release. It never exceeds MAX_INFLIGHT and never underflows.
//  Flush
//  - Next edge: busy_vec=0, inflight=0.
//  - Issue and wb in the same cycle are ignored; wb_err is not updated.
//  - stall_cnt and wb_err keep their values.
//  Stall counter
//  - stall_cnt increments when issue_valid & !issue_ready & !flush.
//  - It holds at 2^STALL_W-1.
//  Invariant
//  - inflight == popcount(busy_vec) every cycle.
// TESTING
//  1. rst, then I-type dest=5 fired -> busy_vec=0x20, inflight=1.
//     Next cycle S-type src1=5 -> issue_ready=0, stall_cnt increments.
//  2. With r5 busy: wb_valid, wb_dest=5 and S-type src1=5 dest=6 in the same cycle
//     -> issue_ready=1; next cycle busy_vec=0x40, inflight=1.
//  3. Fire 4 I-type writes to r1..r4 (MAX=4) -> inflight=4.
//     A 5th write to r7 -> ready=0. A B-type src2=9 -> ready=1, inflight unchanged.
//  4. wb_valid, wb_dest=12 with r12 not busy -> wb_err=1 and stays 1.
//     wb_dest=0 -> no busy change.
//  5. r3 and r8 busy, flush with issue of dest=9 in the same cycle
//     -> next cycle busy_vec=0, inflight=0, r9 not busy.
//  6. Hold a RAW stall for 2^STALL_W+5 cycles -> stall_cnt saturates at all-ones.
//     Assert rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register scoreboard and issue gate between decode and execute
// Holds issue on RAW/WAW hazards or when too many register writes are outstanding.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3,
  parameter int STALL_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         src1,
  input  logic [4:0]         src2,
  input  logic [4:0]         dest,
  input  logic               wb_valid,
  input  logic [4:0]         wb_dest,
  output logic [31:0]        busy_vec,
  output logic [CNT_W-1:0]   inflight,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               wb_err
);

  localparam logic [CNT_W:0] MaxInflight = MAX_INFLIGHT[CNT_W:0];

  logic [31:0]        busy_q, busy_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               wb_err_q, wb_err_d;

  logic        reads1, reads2, writes;
  logic [31:0] wb_mask, busy_eff, set_mask;
  logic        wb_release, raw, waw, cap_full, fire, fire_write;
  logic [CNT_W:0] inflight_net;

  always_comb begin
    reads1 = (issue_type == 2'b01) || (issue_type == 2'b10);
    reads2 = (issue_type == 2'b01) || (issue_type == 2'b11);
    writes = (issue_type == 2'b01) || (issue_type == 2'b10);

    wb_mask    = wb_valid ? (32'd1 << wb_dest) : 32'd0;
    busy_eff   = busy_q & ~wb_mask;
    wb_release = wb_valid && busy_q[wb_dest] && (wb_dest != 5'd0);

    // r0 is never busy, so a zero operand can never hazard.
    raw = (reads1 && (src1 != 5'd0) && busy_eff[src1]) ||
          (reads2 && (src2 != 5'd0) && busy_eff[src2]);
    waw = writes && busy_eff[dest];

    inflight_net = {1'b0, inflight_q} - {{CNT_W{1'b0}}, wb_release};
    cap_full     = writes && (dest != 5'd0) && (inflight_net >= MaxInflight);

    issue_ready = !flush && !raw && !waw && !cap_full;
    fire        = issue_valid && issue_ready;
    fire_write  = fire && writes && (dest != 5'd0);
    set_mask    = fire_write ? (32'd1 << dest) : 32'd0;
  end

  always_comb begin
    busy_d     = busy_q;
    inflight_d = inflight_q;
    wb_err_d   = wb_err_q;
    stall_d    = stall_q;
    if (flush) begin
      busy_d     = 32'd0;
      inflight_d = '0;
    end else begin
      // Release first, then set: a same-cycle wb and issue to one reg leaves it busy.
      busy_d     = (busy_q & ~(wb_release ? wb_mask : 32'd0)) | set_mask;
      inflight_d = inflight_q + {{(CNT_W-1){1'b0}}, fire_write}
                              - {{(CNT_W-1){1'b0}}, wb_release};
      if (wb_valid && !wb_release) wb_err_d = 1'b1;
      if (issue_valid && !issue_ready && !(&stall_q)) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= 32'd0;
      inflight_q <= '0;
      stall_q    <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign busy_vec  = busy_q;
  assign inflight  = inflight_q;
  assign stall_cnt = stall_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - table-driven self-checking bench for issue_scoreboard
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, wb_valid;
  logic        issue_ready, wb_err;
  logic [1:0]  issue_type;
  logic [4:0]  src1, src2, dest, wb_dest;
  logic [31:0] busy_vec;
  logic [2:0]  inflight;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(3), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_type(issue_type), .src1(src1),
    .src2(src2), .dest(dest), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .busy_vec(busy_vec), .inflight(inflight), .stall_cnt(stall_cnt),
    .wb_err(wb_err)
  );

  typedef struct {
    logic        rst, flush, iv;
    logic [1:0]  ty;
    logic [4:0]  s1, s2, d;
    logic        wbv;
    logic [4:0]  wbd;
    logic        chk_rdy, rdy;
    logic [31:0] busy;
    logic [2:0]  inf;
    logic [15:0] stall;
    logic        err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] busy;
    logic [2:0]  inf;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [1:0] ty,
                              logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                              logic wbv, logic [4:0] wbd, logic cr, logic rdy,
                              logic [31:0] busy, logic [2:0] inf,
                              logic [15:0] stall, logic err);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ty = ty; v.s1 = s1; v.s2 = s2; v.d = d;
    v.wbv = wbv; v.wbd = wbd; v.chk_rdy = cr; v.rdy = rdy; v.busy = busy;
    v.inf = inf; v.stall = stall; v.err = err;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; flush = v.flush; issue_valid = v.iv; issue_type = v.ty;
    src1 = v.s1; src2 = v.s2; dest = v.d; wb_valid = v.wbv; wb_dest = v.wbd;
  endtask

  task automatic check_state(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check($sformatf("%s[%0d].busy", tag, e.idx), busy_vec, e.busy);
    check($sformatf("%s[%0d].inflight", tag, e.idx), {29'd0, inflight}, {29'd0, e.inf});
    check($sformatf("%s[%0d].stall", tag, e.idx), {16'd0, stall_cnt}, {16'd0, e.stall});
    check($sformatf("%s[%0d].wb_err", tag, e.idx), {31'd0, wb_err}, {31'd0, e.err});
    check($sformatf("%s[%0d].popcount", tag, e.idx), {29'd0, inflight},
          32'($countones(busy_vec)));
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_type = 2'b00;
    src1 = '0; src2 = '0; dest = '0; wb_valid = 1'b0; wb_dest = '0;

    //          rst f iv ty     s1  s2  d   wbv wbd cr rdy busy          inf stall err
    vt.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0,  0, 0,  0, 0, 32'h0,        0, 0, 0));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 5,  0, 0,  1, 1, 32'h20,       1, 0, 0));
    vt.push_back(mk(0, 0, 1, 2'b01, 5, 0, 6,  0, 0,  1, 0, 32'h20,       1, 1, 0));
    vt.push_back(mk(0, 0, 1, 2'b01, 5, 0, 6,  1, 5,  1, 1, 32'h40,       1, 1, 0));
    vt.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  1, 6,  1, 1, 32'h0,        0, 1, 0));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 1,  0, 0,  1, 1, 32'h2,        1, 1, 0));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 2,  0, 0,  1, 1, 32'h6,        2, 1, 0));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 3,  0, 0,  1, 1, 32'hE,        3, 1, 0));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 4,  0, 0,  1, 1, 32'h1E,       4, 1, 0));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 7,  0, 0,  1, 0, 32'h1E,       4, 2, 0));
    vt.push_back(mk(0, 0, 1, 2'b11, 0, 9, 0,  0, 0,  1, 1, 32'h1E,       4, 2, 0));
    vt.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  1, 12, 1, 1, 32'h1E,       4, 2, 1));
    vt.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  1, 0,  1, 1, 32'h1E,       4, 2, 1));
    vt.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  0, 0,  1, 1, 32'h1E,       4, 2, 1));
    // full, but a same-cycle release frees a slot
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 8,  1, 1,  1, 1, 32'h11C,      4, 2, 1));
    vt.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  1, 2,  1, 1, 32'h118,      3, 2, 1));
    vt.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  1, 4,  1, 1, 32'h108,      2, 2, 1));
    vt.push_back(mk(0, 1, 1, 2'b10, 0, 0, 9,  1, 3,  1, 0, 32'h0,        0, 2, 1));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 9,  0, 0,  1, 1, 32'h200,      1, 2, 1));
    vt.push_back(mk(0, 0, 1, 2'b10, 9, 0, 0,  0, 0,  1, 0, 32'h200,      1, 3, 1));
    vt.push_back(mk(0, 0, 1, 2'b10, 0, 0, 0,  0, 0,  1, 1, 32'h200,      1, 3, 1));
    vt.push_back(mk(0, 0, 1, 2'b01, 0, 0, 9,  0, 0,  1, 0, 32'h200,      1, 4, 1));
    vt.push_back(mk(0, 0, 1, 2'b11, 9, 0, 0,  0, 0,  1, 1, 32'h200,      1, 4, 1));

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i]);
      e.idx = i; e.busy = vt[i].busy; e.inf = vt[i].inf;
      e.stall = vt[i].stall; e.err = vt[i].err;
      sb.push_back(e);
      #2;
      if (vt[i].chk_rdy)
        check($sformatf("vec[%0d].ready", i), {31'd0, issue_ready}, {31'd0, vt[i].rdy});
      @(posedge clk);
      #1;
      check_state("vec");
    end

    // RAW stall on r9 long enough to saturate the 16-bit counter
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b1; issue_type = 2'b10;
    src1 = 5'd9; src2 = '0; dest = 5'd10; wb_valid = 1'b0; wb_dest = '0;
    #2;
    check("sat.ready", {31'd0, issue_ready}, 32'd0);
    e.idx = 0; e.busy = 32'h200; e.inf = 3'd1; e.stall = 16'hFFFF; e.err = 1'b1;
    sb.push_back(e);
    repeat ((1 << 16) + 5) @(posedge clk);
    #1;
    check_state("sat");

    // reset mid-stall clears everything despite the stalled instruction
    @(negedge clk);
    rst = 1'b1; wb_valid = 1'b1; wb_dest = 5'd12;
    e.idx = 1; e.busy = 32'h0; e.inf = 3'd0; e.stall = 16'h0; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_state("rst");

    check("sb.drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
